hist_bin_ctrl: RTL and testbench

HIST_BIN_CTRL -- requirements
Module: hist_bin_ctrl

---
 rtl/hist_bin_ctrl.sv | 124 ++++++++++++
 tb/tb_hist_bin_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_bin_ctrl.sv
// Histogram bin controller: counts samples into NBINS saturating bins, with
// a sequential clear sweep and a ready/valid dump stream of the frozen bins.
module hist_bin_ctrl #(
  parameter int NBINS = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic [7:0]               sample_data,
  output logic                     sample_ready,
  input  logic                     clear_req,
  input  logic                     dump_req,
  input  logic                     dump_ready,
  output logic                     dump_valid,
  output logic [$clog2(NBINS)-1:0] dump_bin,
  output logic [CNT_W-1:0]         dump_count,
  output logic                     dump_done,
  output logic [15:0]              total,
  output logic                     ovf,
  output logic                     busy
);

  localparam int BW = $clog2(NBINS);

  typedef enum logic [1:0] {IDLE, CLEAR, DUMP} state_t;

  state_t                      state_q, state_d;
  logic [NBINS-1:0][CNT_W-1:0] bins_q, bins_d;
  logic [BW-1:0]               idx_q, idx_d;
  logic [15:0]                 total_q, total_d;
  logic                        ovf_q, ovf_d;
  logic                        done_q, done_d;

  logic [BW-1:0] sample_bin;
  logic          accept;
  logic          last_idx;
  logic          unused_lsbs;

  // Bin is taken from the top BW bits of the sample.
  assign sample_bin   = sample_data[7 -: BW];
  assign unused_lsbs  = ^sample_data[7-BW:0];
  assign sample_ready = (state_q == IDLE) & ~clear_req & ~dump_req & ~rst;
  assign accept       = sample_valid & sample_ready;
  assign last_idx     = (idx_q == BW'(NBINS-1));

  always_comb begin
    state_d = state_q;
    bins_d  = bins_q;
    idx_d   = idx_q;
    total_d = total_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (accept) begin
          if (bins_q[sample_bin] == '1) ovf_d = 1'b1;
          else bins_d[sample_bin] = bins_q[sample_bin] + CNT_W'(1);
          if (total_q != 16'hFFFF) total_d = total_q + 16'd1;
        end
        if (clear_req)     state_d = CLEAR;
        else if (dump_req) state_d = DUMP;
      end
      CLEAR: begin
        // One bin per cycle; totals drop with the final bin so the sweep
        // looks atomic to anyone watching total/ovf.
        bins_d[idx_q] = '0;
        idx_d         = idx_q + BW'(1);
        if (last_idx) begin
          total_d = '0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      DUMP: begin
        if (clear_req) begin
          idx_d   = '0;
          state_d = CLEAR;
        end else if (dump_ready) begin
          if (last_idx) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + BW'(1);
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bins_q  <= '0;
      idx_q   <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bins_q  <= bins_d;
      idx_q   <= idx_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign dump_valid = (state_q == DUMP);
  assign dump_bin   = dump_valid ? idx_q : '0;
  assign dump_count = dump_valid ? bins_q[idx_q] : '0;
  assign dump_done  = done_q;
  assign total      = total_q;
  assign ovf        = ovf_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_hist_bin_ctrl.sv
// Directed bench for hist_bin_ctrl: a vector table for the basic flow plus
// hand-written sequences for saturation, throttled dump, abort and reset.
module tb_hist_bin_ctrl;

  logic        clk = 1'b0;
  logic        rst, sample_valid, clear_req, dump_req, dump_ready;
  logic [7:0]  sample_data;
  logic        sample_ready, dump_valid, dump_done, ovf, busy;
  logic [2:0]  dump_bin;
  logic [7:0]  dump_count;
  logic [15:0] total;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_b [8];

  hist_bin_ctrl #(.NBINS(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .clear_req(clear_req), .dump_req(dump_req), .dump_ready(dump_ready),
    .dump_valid(dump_valid), .dump_bin(dump_bin), .dump_count(dump_count),
    .dump_done(dump_done), .total(total), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sv; logic [7:0] sd; logic clr, dmp, rdy;
    logic e_sr, e_busy, e_dv; logic [2:0] e_bin; logic [7:0] e_cnt;
    logic [15:0] e_tot; logic e_ovf, e_done;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic sv, input logic [7:0] sd, input logic clr, dmp, rdy,
                     input logic sr, bz, dv, input logic [2:0] bn, input logic [7:0] cn,
                     input logic [15:0] tt, input logic ov, dn);
    vec_t v;
    v.sv = sv; v.sd = sd; v.clr = clr; v.dmp = dmp; v.rdy = rdy;
    v.e_sr = sr; v.e_busy = bz; v.e_dv = dv; v.e_bin = bn; v.e_cnt = cn;
    v.e_tot = tt; v.e_ovf = ov; v.e_done = dn;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int n);
    sample_valid = 1'b1;
    sample_data  = d;
    repeat (n) step();
    sample_valid = 1'b0;
  endtask

  // Dump with dump_ready held high and compare every beat against exp_b.
  task automatic do_dump(input string tag);
    dump_req = 1'b1;
    @(negedge clk);
    step();
    dump_req   = 1'b0;
    dump_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("%s_beat%0d", tag, i), {dump_valid, dump_bin, dump_count},
          {1'b1, 3'(i), exp_b[i]});
      step();
    end
    @(negedge clk);
    chk($sformatf("%s_done", tag), {dump_done, dump_valid, busy}, {1'b1, 1'b0, 1'b0});
    dump_ready = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, done_at, beats, nclr;
    logic saw_done;
    logic [2:0] hb;
    logic [7:0] hc;

    rst = 1'b1; sample_valid = 1'b0; sample_data = '0;
    clear_req = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
    hb = '0; hc = '0;
    step(); step();
    sample_valid = 1'b1;
    @(negedge clk);
    chk("reset_state", {sample_ready, busy, dump_valid, dump_done, total, ovf},
        {4'b0000, 16'h0, 1'b0});
    sample_valid = 1'b0;
    rst = 1'b0;
    step();

    //   sv    sd     clr  dmp  rdy   sr   bz   dv   bin   cnt    tot     ovf  dn
    add(1'b0, 8'h00, 1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 3'd0, 8'd0, 16'd0, 1'b0,1'b0);
    add(1'b1, 8'h00, 1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 3'd0, 8'd0, 16'd0, 1'b0,1'b0);
    add(1'b1, 8'h20, 1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 3'd0, 8'd0, 16'd1, 1'b0,1'b0);
    add(1'b1, 8'h20, 1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 3'd0, 8'd0, 16'd2, 1'b0,1'b0);
    add(1'b1, 8'hE0, 1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 3'd0, 8'd0, 16'd3, 1'b0,1'b0);
    add(1'b0, 8'h00, 1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 3'd0, 8'd0, 16'd4, 1'b0,1'b0);
    add(1'b0, 8'h00, 1'b0,1'b0,1'b1, 1'b0,1'b1,1'b1, 3'd0, 8'd1, 16'd4, 1'b0,1'b0);
    add(1'b0, 8'h00, 1'b0,1'b0,1'b1, 1'b0,1'b1,1'b1, 3'd1, 8'd2, 16'd4, 1'b0,1'b0);
    for (int b = 2; b < 7; b++)
      add(1'b0, 8'h00, 1'b0,1'b0,1'b1, 1'b0,1'b1,1'b1, 3'(b), 8'd0, 16'd4, 1'b0,1'b0);
    add(1'b0, 8'h00, 1'b0,1'b0,1'b1, 1'b0,1'b1,1'b1, 3'd7, 8'd1, 16'd4, 1'b0,1'b0);
    add(1'b0, 8'h00, 1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 3'd0, 8'd0, 16'd4, 1'b0,1'b1);
    add(1'b0, 8'h00, 1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 3'd0, 8'd0, 16'd4, 1'b0,1'b0);
    // All three requests at once: clear wins, sample refused, dump dropped.
    add(1'b1, 8'h00, 1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0, 3'd0, 8'd0, 16'd4, 1'b0,1'b0);
    for (int c = 0; c < 8; c++)
      add(1'b1, 8'h00, 1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0, 3'd0, 8'd0, 16'd4, 1'b0,1'b0);
    add(1'b0, 8'h00, 1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 3'd0, 8'd0, 16'd0, 1'b0,1'b0);
    add(1'b0, 8'h00, 1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 3'd0, 8'd0, 16'd0, 1'b0,1'b0);

    foreach (vecs[i]) begin
      sample_valid = vecs[i].sv; sample_data = vecs[i].sd;
      clear_req = vecs[i].clr; dump_req = vecs[i].dmp; dump_ready = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {sample_ready, busy, dump_valid, dump_bin, dump_count, total, ovf, dump_done},
          {vecs[i].e_sr, vecs[i].e_busy, vecs[i].e_dv, vecs[i].e_bin, vecs[i].e_cnt,
           vecs[i].e_tot, vecs[i].e_ovf, vecs[i].e_done});
      step();
    end
    sample_valid = 1'b0; clear_req = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;

    // Saturation: 300 back-to-back samples into bin 2.
    sample_valid = 1'b1;
    sample_data  = 8'h40;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 254) chk("sat_ovf_at255", {ovf, total}, {1'b0, 16'd255});
      if (i == 255) chk("sat_ovf_at256", {ovf, total}, {1'b1, 16'd256});
    end
    sample_valid = 1'b0;
    @(negedge clk);
    chk("sat_total", {ovf, total}, {1'b1, 16'd300});
    step();
    foreach (exp_b[i]) exp_b[i] = 8'd0;
    exp_b[2] = 8'd255;
    do_dump("sat");

    // Throttled dump: dump_ready alternates 0/1 starting low on entry.
    dump_req = 1'b1;
    @(negedge clk);
    step();
    dump_req = 1'b0;
    cyc = 0; done_at = -1; beats = 0;
    while (cyc < 40 && done_at < 0) begin
      dump_ready = (cyc % 2) == 1;
      @(negedge clk);
      if (dump_done) done_at = cyc;
      else if (dump_valid) begin
        if (!dump_ready) begin
          hb = dump_bin; hc = dump_count;
        end else begin
          chk($sformatf("tog_hold%0d", beats), {dump_bin, dump_count}, {hb, hc});
          if (beats < 8)
            chk($sformatf("tog_beat%0d", beats), {dump_bin, dump_count}, {3'(beats), exp_b[beats]});
          beats++;
        end
      end
      step();
      cyc++;
    end
    dump_ready = 1'b0;
    chk("tog_beats", 64'(beats), 64'd8);
    chk("tog_latency", 64'(done_at), 64'd16);
    @(negedge clk);
    chk("tog_total_kept", {ovf, total}, {1'b1, 16'd300});
    step();

    // Abort a dump with clear_req at beat 3.
    dump_req = 1'b1;
    @(negedge clk);
    step();
    dump_req = 1'b0;
    dump_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("abort_at3", {dump_valid, dump_bin}, {1'b1, 3'd3});
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    dump_ready = 1'b0;
    nclr = 0; saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dump_done) saw_done = 1'b1;
      if (!busy) break;
      if (nclr == 0) chk("abort_dv_drop", {dump_valid, dump_count}, {1'b0, 8'd0});
      nclr++;
      step();
    end
    chk("abort_clr_cycles", 64'(nclr), 64'd8);
    chk("abort_no_done", 64'(saw_done), 64'd0);
    chk("abort_idle", {total, ovf, sample_ready}, {16'd0, 1'b0, 1'b1});
    step();
    foreach (exp_b[i]) exp_b[i] = 8'd0;
    do_dump("abort");

    // Reset in the 4th CLEAR cycle; bin 7 is only zeroed by the reset.
    send(8'hE0, 3);
    send(8'h00, 1);
    clear_req = 1'b1;
    @(negedge clk);
    step();
    clear_req = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    sample_valid = 1'b1;
    @(negedge clk);
    chk("rst_clr_sready", {sample_ready, busy}, {1'b0, 1'b1});
    step();
    rst = 1'b0;
    sample_valid = 1'b0;
    @(negedge clk);
    chk("rst_clr_out", {busy, dump_valid, dump_done, total, ovf, sample_ready},
        {3'b000, 16'd0, 1'b0, 1'b1});
    step();
    do_dump("rstclr");

    // Reset in mid-DUMP.
    send(8'hE0, 2);
    dump_req = 1'b1;
    @(negedge clk);
    step();
    dump_req = 1'b0;
    dump_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("rst_dump_at4", {dump_valid, dump_bin}, {1'b1, 3'd4});
    rst = 1'b1;
    step();
    rst = 1'b0;
    dump_ready = 1'b0;
    @(negedge clk);
    chk("rst_dump_out", {busy, dump_valid, dump_bin, dump_count, dump_done, total, ovf},
        {2'b00, 3'd0, 8'd0, 1'b0, 16'd0, 1'b0});
    step();
    do_dump("rstdump");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
